// File: rtl/bcd_sum_display.sv
// bcd_sum_display: decimal correction of the 4-bit adder's raw result
// into a registered two-digit BCD value, with an out-of-range flag and a
// multiplexed two-digit common-anode seven-segment display.
//
// Handshake: load is a strobe with no ready. Every rising edge that sees
// load=1 captures {Cout,S}, so back-to-back loads all capture and the last
// one wins. done is load delayed by one cycle and marks the cycle in which
// the new tens/units/err are first visible.
module bcd_sum_display #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       Cout,
  input  logic [3:0] S,
  output logic [3:0] tens,
  output logic [3:0] units,
  output logic       err,
  output logic       done,
  output logic [1:0] an,
  output logic [6:0] seg
);

  localparam int            CW       = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);

  logic [4:0]    v;
  logic [3:0]    nx_tens;
  logic [3:0]    nx_units;
  logic          nx_err;
  logic [CW-1:0] cnt;
  logic          sel;

  assign v = {Cout, S};

  // Decimal correction: 10..18 take the +6 adjusted low nibble, >18 is an error.
  always_comb begin
    nx_tens  = 4'd0;
    nx_units = 4'd0;
    nx_err   = 1'b0;
    if (v <= 5'd9) begin
      nx_units = S;
    end else if (v <= 5'd18) begin
      nx_tens  = 4'd1;
      nx_units = S + 4'd6;
    end else begin
      nx_err   = 1'b1;
    end
  end

  // Result register: capture on load, hold otherwise; done follows load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tens  <= 4'd0;
      units <= 4'd0;
      err   <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= load;
      if (load) begin
        tens  <= nx_tens;
        units <= nx_units;
        err   <= nx_err;
      end
    end
  end

  // Free-running scan counter; sel flips each time cnt wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      sel <= 1'b0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
      sel <= ~sel;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Active-low {g..a} patterns for decimal digits 0-9.
  function automatic logic [6:0] digit_seg(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'd0:    p = 7'b1000000;
      4'd1:    p = 7'b1111001;
      4'd2:    p = 7'b0100100;
      4'd3:    p = 7'b0110000;
      4'd4:    p = 7'b0011001;
      4'd5:    p = 7'b0010010;
      4'd6:    p = 7'b0000010;
      4'd7:    p = 7'b1111000;
      4'd8:    p = 7'b0000000;
      4'd9:    p = 7'b0010000;
      default: p = 7'b1111111;
    endcase
    return p;
  endfunction

  // Digit drive: dashes on error, leading-zero blanking on the tens digit.
  always_comb begin
    an  = 2'b10;
    seg = digit_seg(units);
    if (err) begin
      an  = sel ? 2'b01 : 2'b10;
      seg = 7'b0111111;
    end else if (sel) begin
      if (tens != 4'd0) begin
        an  = 2'b01;
        seg = digit_seg(tens);
      end else begin
        an  = 2'b11;
        seg = 7'b1111111;
      end
    end
  end

endmodule
